// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: a variable-latency req/ack fetcher filling a small
// prefetch FIFO that presents {instr, PC+4} to the IF/ID boundary.
//
// state | meaning
// IDLE  | no request outstanding (FIFO has no room for another entry)
// WAIT  | request at mem_addr outstanding; its data will be queued
// DROP  | request outstanding but stale after a redirect; its data is discarded
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_out_valid,
  output logic [31:0] o_out_instr,
  output logic [31:0] o_out_pc4
);

  localparam int unsigned   PW   = $clog2(DEPTH);
  localparam int unsigned   CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nx;
  logic          r_mem_req;
  logic          w_mem_req_nx;
  logic [31:0]   r_mem_addr;
  logic [31:0]   w_mem_addr_nx;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nx;

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_sum;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_fifo_pc4   [DEPTH];

  logic          w_out_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_space_next;
  logic [31:0]   w_target;
  logic [31:0]   w_fetch_pc4;

  assign w_target     = {i_redirect_pc[31:2], 2'b00};
  assign w_fetch_pc4  = r_fetch_pc + 32'd4;
  assign w_out_valid  = (r_count != '0);
  assign w_pop        = w_out_valid & ~i_stall & ~i_redirect;
  assign w_push       = (r_state == S_WAIT) & i_mem_ack & ~i_redirect;
  assign w_count_sum  = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
  assign w_space_next = (w_count_sum < FULL);

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_out_valid = w_out_valid;
  assign o_out_instr = w_out_valid ? r_fifo_instr[r_rd_ptr] : 32'd0;
  assign o_out_pc4   = w_out_valid ? r_fifo_pc4[r_rd_ptr]   : 32'd0;

  // In WAIT, mem_addr always equals fetch_pc; in DROP, fetch_pc holds the pending target.
  always_comb begin
    w_state_nx    = r_state;
    w_mem_req_nx  = r_mem_req;
    w_mem_addr_nx = r_mem_addr;
    w_fetch_pc_nx = r_fetch_pc;
    case (r_state)
      S_IDLE: begin
        if (i_redirect) begin
          w_fetch_pc_nx = w_target;
          w_mem_addr_nx = w_target;
          w_mem_req_nx  = 1'b1;
          w_state_nx    = S_WAIT;
        end else if (w_space_next) begin
          w_mem_addr_nx = r_fetch_pc;
          w_mem_req_nx  = 1'b1;
          w_state_nx    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_ack && i_redirect) begin
          w_fetch_pc_nx = w_target;
          w_mem_addr_nx = w_target;
        end else if (i_mem_ack) begin
          w_fetch_pc_nx = w_fetch_pc4;
          if (w_space_next) begin
            w_mem_addr_nx = w_fetch_pc4;
          end else begin
            w_mem_req_nx = 1'b0;
            w_state_nx   = S_IDLE;
          end
        end else if (i_redirect) begin
          w_fetch_pc_nx = w_target;
          w_state_nx    = S_DROP;
        end
      end
      S_DROP: begin
        if (i_mem_ack) begin
          w_state_nx = S_WAIT;
          if (i_redirect) begin
            w_fetch_pc_nx = w_target;
            w_mem_addr_nx = w_target;
          end else begin
            w_mem_addr_nx = r_fetch_pc;
          end
        end else if (i_redirect) begin
          w_fetch_pc_nx = w_target;
        end
      end
      default: begin
        w_state_nx   = S_IDLE;
        w_mem_req_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nx;
      r_mem_req  <= w_mem_req_nx;
      r_mem_addr <= w_mem_addr_nx;
      r_fetch_pc <= w_fetch_pc_nx;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (i_redirect) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_count <= w_count_sum;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Entry storage needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= i_mem_rdata;
      r_fifo_pc4[r_wr_ptr]   <= w_fetch_pc4;
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_push && !w_pop && (r_count == FULL)));

  a_ack_needs_req: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_mem_ack && !r_mem_req));

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end feeding the decode stage of the five-stage CPU.
- Replaces the single-cycle instruction-memory lookup with a variable-latency memory interface (req/ack) and a small prefetch FIFO.
- Presents {instr, PC+4} to the IF/ID boundary.
- Honours the decode-stage load-use stall and the MEM-stage branch redirect (pcsrc/baddr).

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 32'd0, first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- redirect  in  1  branch taken (pcsrc); flush and refetch from redirect_pc.
- redirect_pc  in  32  branch target (baddr_s4); bits [1:0] ignored, treated as 0.
- stall  in  1  decode stall (stall_s1_s2); head entry not consumed this cycle.
- mem_req  out  1  instruction memory request, registered.
- mem_addr  out  32  word-aligned fetch address, registered, stable while mem_req=1.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid in that cycle only.
- mem_rdata  in  32  fetched instruction.
- out_valid  out  1  head entry valid.
- out_instr  out  32  head instruction; 32'd0 (nop) when out_valid=0.
- out_pc4  out  32  head PC+4; 32'd0 when out_valid=0.

Behaviour:
- Reset (async, immediate):
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC.
  - count=0, rd/wr pointers=0, state=IDLE.
  - out_valid=0, out_instr=0, out_pc4=0.
- FIFO:
  - Entry = {instr, pc+4}. count ranges 0..DEPTH.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - out_* are combinational from the head entry; out_valid = (count!=0).
- Pop and push:
  - pop = out_valid & ~stall & ~redirect.
  - push = mem_ack in state WAIT & ~redirect.
  - Simultaneous push and pop at count=DEPTH or count=0 are legal.
  - count updates by push-pop. Overflow is impossible by construction; assert in simulation.
- Space rule: space_next = (count + push - pop) < DEPTH.
- Memory handshake:
  - At most one request outstanding.
  - mem_req stays 1 with mem_addr fixed until mem_ack.
  - An issued request is never withdrawn.
  - mem_ack while mem_req=0 is a protocol error; ignore it and assert in simulation.
- State machine (all transitions on clk):
  - IDLE: if redirect, then fetch_pc<=redirect_pc and go to WAIT, issuing req at redirect_pc. Else if space_next, go to WAIT with mem_addr<=fetch_pc and mem_req<=1. Else stay IDLE.
  - WAIT, no ack, no redirect: hold.
  - WAIT, ack, no redirect: push {mem_rdata, fetch_pc+4}; fetch_pc<=fetch_pc+4. If space_next, stay WAIT with mem_addr<=fetch_pc+4 (back-to-back, one instr/cycle peak). Else go IDLE with mem_req<=0.
  - WAIT, redirect, no ack: fetch_pc<=redirect_pc and go to DROP. mem_req and mem_addr are held.
  - WAIT, redirect and ack in the same cycle: discard the data; go to WAIT with mem_addr<=redirect_pc.
  - DROP, no ack: hold. A further redirect overwrites fetch_pc (the latest target wins).
  - DROP, ack: discard the data; go to WAIT with mem_addr<=fetch_pc, or <=redirect_pc if redirect is asserted that same cycle.
- Redirect effects:
  - Flushes the FIFO: count<=0, pointers<=0.
  - Has priority over pop and push.
  - out_valid=0 from the next cycle until the first post-redirect ack.
- Stall: freezes the head; fetch continues until the FIFO fills.
- Address arithmetic is 32-bit modulo; 0xFFFFFFFC+4 wraps to 0.
- Latency: reset deassertion to first mem_req is 1 cycle. An ack in cycle N gives out_valid in cycle N+1.

Test Plan:
1. Reset with mem_ack returned 1 cycle after each req, stall=0. Expect mem_addr sequence 0,4,8,12 and out_pc4 4,8,12,16 in order, with no gaps after the first entry.
2. stall=1 held for 10 cycles. Expect FIFO to fill to 4, mem_req to drop after the 4th ack, and out_instr to stay on the PC=0 instruction. Release stall: expect pops at one per cycle and mem_req to re-assert.
3. Redirect to 0x40 while idle and full. Expect out_valid=0 the next cycle, mem_addr=0x40, and first output out_pc4=0x44.
4. Redirect to 0x80 while WAIT at addr 0x10 with ack delayed 3 cycles. Expect mem_addr to stay 0x10 until ack, that data to be discarded, the next req to be at 0x80, and nothing from 0x10 to appear at the output.
5. Redirect and ack in the same cycle, and a second redirect (0x100, then 0x200) during DROP. Expect the next req at 0x200 only.
6. Assert rst mid-WAIT. Expect outputs to clear immediately, and the restart to fetch RESET_PC with the stale ack ignored.
